// File: rtl/bus_region_decoder_if.sv
// Bus bundle between the 8088 min-mode CPU side and the region decoder.
// master: CPU/bench side, drives ALE, IOM, RD, WR, BUS_ADDR.
// slave : decoder side, drives Address, CS, READY, UNMAPPED, MULTI_HIT.
interface bus_region_decoder_if #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned NUM_REGIONS = 4
);
  logic                   ALE;
  logic                   IOM;
  logic                   RD;
  logic                   WR;
  logic [ADDR_W-1:0]      BUS_ADDR;
  logic [ADDR_W-1:0]      Address;
  logic [NUM_REGIONS-1:0] CS;
  logic                   READY;
  logic                   UNMAPPED;
  logic                   MULTI_HIT;

  modport master (
    output ALE, IOM, RD, WR, BUS_ADDR,
    input  Address, CS, READY, UNMAPPED, MULTI_HIT
  );

  modport slave (
    input  ALE, IOM, RD, WR, BUS_ADDR,
    output Address, CS, READY, UNMAPPED, MULTI_HIT
  );
endinterface

// File: rtl/bus_region_decoder.sv
// Bus-cycle address latch, chip-select decoder and wait-state generator for
// the 8088 min-mode bus. Latches {A,AD} on ALE, matches it against
// NUM_REGIONS programmable memory/IO windows and drives one-hot CS, READY
// (wait-state insertion) and unmapped / multi-hit pulses.
// Ports:
//   CLK      - bus clock, rising edge
//   RESET_N  - asynchronous active-low reset
//   bus      - slave side of bus_region_decoder_if
//              in : ALE, IOM, RD (act-low), WR (act-low), BUS_ADDR
//              out: Address, CS, READY, UNMAPPED, MULTI_HIT (all registered)
module bus_region_decoder #(
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned IO_ADDR_W   = 16,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LSB =
    {20'h01C00, 20'h0FF00, 20'h8FFFF, 20'h00000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MSB =
    {20'h01DFF, 20'h0FF0F, 20'hFFFFF, 20'h7FFFF},
  parameter logic [NUM_REGIONS-1:0]        REGION_IS_IO = 4'b1100,
  parameter logic [NUM_REGIONS*4-1:0]      REGION_WAIT  =
    {4'd0, 4'd1, 4'd2, 4'd0}
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  bus_region_decoder_if.slave  bus
);

  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_XFER  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   iom_q, iom_d;
  logic [NUM_REGIONS-1:0] cs_q, cs_d;
  logic                   ready_q, ready_d;
  logic                   unmapped_q, unmapped_d;
  logic                   multi_hit_q, multi_hit_d;
  logic [WAIT_W-1:0]      cnt_q, cnt_d;
  logic                   seen_q, seen_d;

  logic [ADDR_W-1:0]      cmp_addr;
  logic [NUM_REGIONS-1:0] hit;
  logic [NUM_REGIONS-1:0] win_cs;
  logic [WAIT_W-1:0]      win_wait;
  logic                   multi_c;
  logic                   strobe_c;

  // Region match vector and lowest-index winner for the latched address.
  always_comb begin
    cmp_addr = iom_q ? ADDR_W'(addr_q[IO_ADDR_W-1:0]) : addr_q;
    hit      = '0;
    for (int i = 0; i < int'(NUM_REGIONS); i++) begin
      hit[i] = (REGION_IS_IO[i] == iom_q) &&
               (cmp_addr >= REGION_LSB[i*ADDR_W +: ADDR_W]) &&
               (cmp_addr <= REGION_MSB[i*ADDR_W +: ADDR_W]);
    end
    win_cs   = '0;
    win_wait = '0;
    // Descending scan so the lowest matching index is written last.
    for (int i = int'(NUM_REGIONS) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_cs    = '0;
        win_cs[i] = 1'b1;
        win_wait  = REGION_WAIT[i*WAIT_W +: WAIT_W];
      end
    end
    multi_c  = ($countones(hit) > 1);
    strobe_c = !bus.RD || !bus.WR;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    iom_d       = iom_q;
    cs_d        = cs_q;
    ready_d     = ready_q;
    unmapped_d  = 1'b0;
    multi_hit_d = 1'b0;
    cnt_d       = cnt_q;
    seen_d      = seen_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.ALE) begin
          addr_d  = bus.BUS_ADDR;
          iom_d   = bus.IOM;
          seen_d  = 1'b0;
          state_d = ST_LATCH;
        end
      end

      ST_LATCH: begin
        if (bus.ALE) begin
          addr_d = bus.BUS_ADDR;
          iom_d  = bus.IOM;
        end else begin
          cs_d        = win_cs;
          multi_hit_d = multi_c;
          seen_d      = seen_q | strobe_c;
          if (hit == '0) begin
            unmapped_d = 1'b1;
            state_d    = ST_XFER;
          end else if (win_wait != '0) begin
            cnt_d   = win_wait;
            ready_d = 1'b0;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_XFER;
          end
        end
      end

      ST_WAIT, ST_XFER: begin
        if (bus.ALE) begin
          // New address phase aborts whatever cycle is in flight.
          cs_d    = '0;
          ready_d = 1'b1;
          addr_d  = bus.BUS_ADDR;
          iom_d   = bus.IOM;
          cnt_d   = '0;
          seen_d  = 1'b0;
          state_d = ST_LATCH;
        end else if (state_q == ST_WAIT) begin
          // READY stays low for the full count regardless of strobes.
          seen_d = seen_q | strobe_c;
          cnt_d  = cnt_q - WAIT_W'(1);
          if (cnt_q == WAIT_W'(1)) begin
            ready_d = 1'b1;
            state_d = ST_XFER;
          end
        end else if (seen_q && bus.RD && bus.WR) begin
          cs_d    = '0;
          state_d = ST_IDLE;
        end else begin
          seen_d = seen_q | strobe_c;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      iom_q       <= 1'b0;
      cs_q        <= '0;
      ready_q     <= 1'b1;
      unmapped_q  <= 1'b0;
      multi_hit_q <= 1'b0;
      cnt_q       <= '0;
      seen_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      iom_q       <= iom_d;
      cs_q        <= cs_d;
      ready_q     <= ready_d;
      unmapped_q  <= unmapped_d;
      multi_hit_q <= multi_hit_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
    end
  end

  assign bus.Address   = addr_q;
  assign bus.CS        = cs_q;
  assign bus.READY     = ready_q;
  assign bus.UNMAPPED  = unmapped_q;
  assign bus.MULTI_HIT = multi_hit_q;

endmodule

// File: tb/tb_bus_region_decoder.sv
// Bench for bus_region_decoder: two instances share one stimulus stream,
// dut0 with the default map and dut1 with R1's lower bound moved to 7FFF0
// so that R0/R1 overlap. Expectations come from a table-driven window model.
module tb_bus_region_decoder;
  localparam int unsigned NR = 4;
  localparam int unsigned AW = 20;
  localparam logic [NR*AW-1:0] LSB0 = {20'h01C00, 20'h0FF00, 20'h8FFFF, 20'h00000};
  localparam logic [NR*AW-1:0] LSB1 = {20'h01C00, 20'h0FF00, 20'h7FFF0, 20'h00000};
  localparam logic [NR*AW-1:0] MSBS = {20'h01DFF, 20'h0FF0F, 20'hFFFFF, 20'h7FFFF};
  localparam logic [NR-1:0]    ISIO = 4'b1100;
  localparam logic [NR*4-1:0]  WTS  = {4'd0, 4'd1, 4'd2, 4'd0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_region_decoder_if #(.ADDR_W(AW), .NUM_REGIONS(NR)) bus0 ();
  bus_region_decoder_if #(.ADDR_W(AW), .NUM_REGIONS(NR)) bus1 ();

  assign bus1.ALE      = bus0.ALE;
  assign bus1.IOM      = bus0.IOM;
  assign bus1.RD       = bus0.RD;
  assign bus1.WR       = bus0.WR;
  assign bus1.BUS_ADDR = bus0.BUS_ADDR;

  bus_region_decoder #(.NUM_REGIONS(NR), .ADDR_W(AW), .IO_ADDR_W(16),
    .REGION_LSB(LSB0), .REGION_MSB(MSBS), .REGION_IS_IO(ISIO), .REGION_WAIT(WTS))
    dut0 (.CLK(clk), .RESET_N(rst_n), .bus(bus0.slave));

  bus_region_decoder #(.NUM_REGIONS(NR), .ADDR_W(AW), .IO_ADDR_W(16),
    .REGION_LSB(LSB1), .REGION_MSB(MSBS), .REGION_IS_IO(ISIO), .REGION_WAIT(WTS))
    dut1 (.CLK(clk), .RESET_N(rst_n), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;

  // Reference window table (bounds inclusive), one lower-bound row per DUT.
  int unsigned m_lsb [2][4] = '{'{'h00000, 'h8FFFF, 'hFF00, 'h1C00},
                                '{'h00000, 'h7FFF0, 'hFF00, 'h1C00}};
  int unsigned m_msb [4]    = '{'h7FFFF, 'hFFFFF, 'hFF0F, 'h1DFF};
  bit          m_io  [4]    = '{1'b0, 1'b0, 1'b1, 1'b1};
  int          m_wait[4]    = '{0, 2, 1, 0};

  function automatic void model(input int d, input int unsigned addr, input bit iom,
                                output logic [3:0] cs, output int wt,
                                output bit unm, output bit multi);
    int unsigned a = iom ? (addr % 65536) : addr;
    int hits = 0;
    int win  = -1;
    for (int i = 0; i < 4; i++) begin
      if (m_io[i] == iom && a >= m_lsb[d][i] && a <= m_msb[i]) begin
        hits++;
        if (win < 0) win = i;
      end
    end
    cs    = (win < 0) ? 4'b0000 : 4'(1 << win);
    wt    = (win < 0) ? 0 : m_wait[win];
    unm   = (win < 0);
    multi = (hits >= 2);
  endfunction

  // Categories: 0 Address, 1 CS, 2 READY, 3 UNMAPPED, 4 MULTI_HIT.
  function automatic logic [31:0] get(input int d, input int c);
    if (d == 0) begin
      case (c)
        0: return 32'(bus0.Address);
        1: return 32'(bus0.CS);
        2: return 32'(bus0.READY);
        3: return 32'(bus0.UNMAPPED);
        default: return 32'(bus0.MULTI_HIT);
      endcase
    end else begin
      case (c)
        0: return 32'(bus1.Address);
        1: return 32'(bus1.CS);
        2: return 32'(bus1.READY);
        3: return 32'(bus1.UNMAPPED);
        default: return 32'(bus1.MULTI_HIT);
      endcase
    end
  endfunction

  string       cname [5] = '{"address", "cs", "ready", "unmapped", "multi_hit"};
  int          o_bad [2][5];
  logic [31:0] o_act [2][5];
  logic [31:0] o_exp [2][5];
  logic [3:0]  o_cs0 [2];
  int          o_rlow[2];
  int          o_unm [2];
  int          o_mh  [2];

  // Records a sample that disagrees with the model for later reporting.
  task automatic note(input int d, input int c, input logic [31:0] exp);
    logic [31:0] act = get(d, c);
    if (act !== exp) begin
      o_bad[d][c]++;
      o_act[d][c] = act;
      o_exp[d][c] = exp;
    end
  endtask

  // One complete bus cycle, every output of both DUTs sampled each negedge.
  task automatic run_cycle(input logic [19:0] addr, input bit iom, input bit wr,
                           input int ale_len, input int extra);
    logic [3:0] ecs[2];
    int         ewt[2];
    bit         eun[2], emh[2];
    int         hold;
    for (int d = 0; d < 2; d++) begin
      model(d, 32'(addr), iom, ecs[d], ewt[d], eun[d], emh[d]);
      for (int c = 0; c < 5; c++) o_bad[d][c] = 0;
      o_rlow[d] = 0; o_unm[d] = 0; o_mh[d] = 0;
    end
    hold = ((ewt[0] > ewt[1]) ? ewt[0] : ewt[1]) + extra;

    @(posedge clk); #1;
    for (int j = 0; j < ale_len; j++) begin
      bus0.ALE      = 1'b1;
      bus0.IOM      = (j == ale_len - 1) ? iom : 1'($urandom);
      bus0.BUS_ADDR = (j == ale_len - 1) ? addr : 20'($urandom);
      @(posedge clk); #1;
    end
    bus0.ALE      = 1'b0;
    bus0.BUS_ADDR = 20'($urandom);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      note(d, 0, 32'(addr)); note(d, 1, 0); note(d, 2, 1); note(d, 3, 0); note(d, 4, 0);
    end
    @(posedge clk); #1;
    if (wr) bus0.WR = 1'b0; else bus0.RD = 1'b0;
    for (int k = 0; k <= hold + 1; k++) begin
      if (k == hold) begin bus0.RD = 1'b1; bus0.WR = 1'b1; end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (k == 0) o_cs0[d] = 4'(get(d, 1));
        if (get(d, 2) == 0) o_rlow[d]++;
        if (get(d, 3) == 1) o_unm[d]++;
        if (get(d, 4) == 1) o_mh[d]++;
        note(d, 0, 32'(addr));
        note(d, 1, (k <= hold) ? 32'(ecs[d]) : 0);
        note(d, 2, (k < ewt[d]) ? 0 : 1);
        note(d, 3, (k == 0 && eun[d]) ? 1 : 0);
        note(d, 4, (k == 0 && emh[d]) ? 1 : 0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 5; c++) begin
        logic [31:0] exp = (c == 2) ? 1 : 0;
        checks++;
        if (get(d, c) !== exp) begin
          errors++;
          $display("FAIL reset dut%0d %s: got %h expected %h", d, cname[c], get(d, c), exp);
        end
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [19:0] a;
    bit          iom;
    bit          wr;
    logic [3:0]  cs  [2];
    int          w   [2];
    int          unm [2];
    int          mh  [2];
  } dir_t;

  // Address map scenarios with hand-derived expectations.
  task automatic test_directed();
    dir_t t[9];
    t[0] = '{20'h12345, 1'b0, 1'b0, '{4'b0001, 4'b0001}, '{0, 0}, '{0, 0}, '{0, 0}};
    t[1] = '{20'hA0000, 1'b0, 1'b1, '{4'b0010, 4'b0010}, '{2, 2}, '{0, 0}, '{0, 0}};
    t[2] = '{20'hFFF05, 1'b1, 1'b0, '{4'b0100, 4'b0100}, '{1, 1}, '{0, 0}, '{0, 0}};
    t[3] = '{20'hFFF05, 1'b0, 1'b0, '{4'b0010, 4'b0010}, '{2, 2}, '{0, 0}, '{0, 0}};
    t[4] = '{20'h85000, 1'b0, 1'b0, '{4'b0000, 4'b0010}, '{0, 2}, '{1, 0}, '{0, 0}};
    t[5] = '{20'h7FFF8, 1'b0, 1'b1, '{4'b0001, 4'b0001}, '{0, 0}, '{0, 0}, '{0, 1}};
    t[6] = '{20'h31C00, 1'b1, 1'b1, '{4'b1000, 4'b1000}, '{0, 0}, '{0, 0}, '{0, 0}};
    t[7] = '{20'h01E00, 1'b1, 1'b0, '{4'b0000, 4'b0000}, '{0, 0}, '{1, 1}, '{0, 0}};
    t[8] = '{20'h8FFFF, 1'b0, 1'b0, '{4'b0010, 4'b0010}, '{2, 2}, '{0, 0}, '{0, 0}};
    for (int n = 0; n < 9; n++) begin
      run_cycle(t[n].a, t[n].iom, t[n].wr, 1 + (n % 2), 1 + (n % 3));
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_cs0[d] !== t[n].cs[d]) begin
          errors++;
          $display("FAIL directed[%0d] dut%0d cs: got %b expected %b", n, d, o_cs0[d], t[n].cs[d]);
        end
        checks++;
        if (o_rlow[d] !== t[n].w[d]) begin
          errors++;
          $display("FAIL directed[%0d] dut%0d wait_cycles: got %0d expected %0d", n, d, o_rlow[d], t[n].w[d]);
        end
        checks++;
        if (o_unm[d] !== t[n].unm[d] || o_mh[d] !== t[n].mh[d]) begin
          errors++;
          $display("FAIL directed[%0d] dut%0d pulses: got unm=%0d mh=%0d expected unm=%0d mh=%0d",
                   n, d, o_unm[d], o_mh[d], t[n].unm[d], t[n].mh[d]);
        end
        for (int c = 0; c < 5; c++) begin
          checks++;
          if (o_bad[d][c] !== 0) begin
            errors++;
            $display("FAIL directed[%0d] dut%0d %s: got %h expected %h (%0d samples)",
                     n, d, cname[c], o_act[d][c], o_exp[d][c], o_bad[d][c]);
          end
        end
      end
    end
  endtask

  // Random cycles, biased to window edges, checked sample-by-sample vs model.
  task automatic test_random();
    logic [19:0] edges[16];
    logic [19:0] a;
    bit          iom;
    edges = '{20'h00000, 20'h7FFFF, 20'h80000, 20'h8FFFE, 20'h8FFFF, 20'hFFFFF,
              20'h7FFF0, 20'h7FFEF, 20'h0FF00, 20'h0FEFF, 20'h0FF0F, 20'h0FF10,
              20'h01C00, 20'h01BFF, 20'h01DFF, 20'h01E00};
    for (int n = 0; n < 60; n++) begin
      iom = 1'($urandom);
      if ($urandom_range(0, 1) == 0) a = edges[$urandom_range(0, 15)];
      else a = 20'($urandom);
      if (iom) a[19:16] = 4'($urandom);
      run_cycle(a, iom, 1'($urandom), $urandom_range(1, 3), $urandom_range(1, 3));
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 5; c++) begin
          checks++;
          if (o_bad[d][c] !== 0) begin
            errors++;
            $display("FAIL random[%0d] a=%h iom=%0d dut%0d %s: got %h expected %h",
                     n, a, iom, d, cname[c], o_act[d][c], o_exp[d][c]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    @(posedge clk); #1;
    bus0.ALE = 1'b1; bus0.IOM = 1'b0; bus0.BUS_ADDR = 20'hA0000;
    @(posedge clk); #1;
    bus0.ALE = 1'b0;
    @(posedge clk); #1;
    bus0.WR = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (get(d, 2) !== 0 || get(d, 1) !== 32'h2) begin
        errors++;
        $display("FAIL rst_wait_pre dut%0d: got ready=%0d cs=%h expected ready=0 cs=2", d, get(d, 2), get(d, 1));
      end
    end
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (get(d, 2) !== 1 || get(d, 1) !== 0 || get(d, 0) !== 0) begin
        errors++;
        $display("FAIL rst_wait_async dut%0d: got ready=%0d cs=%h addr=%h expected 1/0/0",
                 d, get(d, 2), get(d, 1), get(d, 0));
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1; bus0.WR = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (get(d, 2) !== 1 || get(d, 1) !== 0) begin
        errors++;
        $display("FAIL rst_wait_after dut%0d: got ready=%0d cs=%h expected 1/0", d, get(d, 2), get(d, 1));
      end
    end
  endtask

  task automatic test_abort_xfer();
    @(posedge clk); #1;
    bus0.ALE = 1'b1; bus0.IOM = 1'b0; bus0.BUS_ADDR = 20'h12345;
    @(posedge clk); #1;
    bus0.ALE = 1'b0; bus0.BUS_ADDR = 20'($urandom);
    @(posedge clk); #1;
    bus0.RD = 1'b0;
    @(posedge clk); #1;
    bus0.ALE = 1'b1; bus0.IOM = 1'b1; bus0.BUS_ADDR = 20'h3FF05; bus0.RD = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (get(d, 1) !== 32'h1) begin
        errors++;
        $display("FAIL abort_pre dut%0d cs: got %h expected 1", d, get(d, 1));
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (get(d, 1) !== 0 || get(d, 0) !== 32'h3FF05 || get(d, 2) !== 1) begin
        errors++;
        $display("FAIL abort_latch dut%0d: got cs=%h addr=%h ready=%0d expected 0/3ff05/1",
                 d, get(d, 1), get(d, 0), get(d, 2));
      end
    end
    @(posedge clk); #1;
    bus0.ALE = 1'b0;
    @(posedge clk); #1;
    bus0.RD = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (get(d, 1) !== 32'h4 || get(d, 2) !== 0) begin
        errors++;
        $display("FAIL abort_redecode dut%0d: got cs=%h ready=%0d expected 4/0", d, get(d, 1), get(d, 2));
      end
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus0.RD = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (get(d, 1) !== 0 || get(d, 2) !== 1) begin
        errors++;
        $display("FAIL abort_end dut%0d: got cs=%h ready=%0d expected 0/1", d, get(d, 1), get(d, 2));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus0.ALE      = 1'b0;
    bus0.IOM      = 1'b0;
    bus0.RD       = 1'b1;
    bus0.WR       = 1'b1;
    bus0.BUS_ADDR = '0;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_wait();
    test_abort_xfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
